fetch_sequencer: RTL and testbench

//  Sequences instruction fetch for the single-issue RISC-V core: owns the fetch PC, drives the

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_queue.sv | 57 +++++
 rtl/fetch_sequencer.sv | 89 ++++++++
 tb/tb_fetch_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch sequencer
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    localparam logic [31:0] PC_INCR = 32'd4;
    localparam int          ENTRY_W = 64;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - small power-of-two FIFO holding fetched {pc,instr} entries
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [WIDTH-1:0]           head_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Flush wins over push/pop: a redirect discards everything younger than the popped head.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch PC owner, imem address driver and decode-facing fetch queue
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        halt_req,
    input  logic        taken_br,
    input  logic [31:0] br_tgt_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        busy
);

    localparam int CW = $clog2(QDEPTH) + 1;

    state_e       state_q;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count;
    fetch_entry_t wentry, head;
    logic         pop, push, full, drained;

    assign out_valid = (count != '0);
    assign full      = (count == CW'(QDEPTH));
    assign pop       = out_valid & out_ready;
    assign push      = (state_q == S_FETCH) & ~halt_req & ~taken_br & (~full | pop);
    // Only a pop can move the queue while draining, so this is "empty after this cycle".
    assign drained   = (count == '0) | ((count == CW'(1)) & pop);

    assign wentry.pc    = fetch_pc_q;
    assign wentry.instr = imem_instr;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (taken_br)  fetch_pc_d = align_pc(br_tgt_pc);
        else if (push) fetch_pc_d = fetch_pc_q + PC_INCR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            case (state_q)
                S_IDLE: begin
                    if (go && !halt_req) state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (halt_req) state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (taken_br)              state_q <= S_IDLE;
                    else if (go && !halt_req)  state_q <= S_FETCH;
                    else if (drained)          state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (wentry),
        .pop_i   (pop),
        .flush_i (taken_br),
        .count_o (count),
        .head_o  (head)
    );

    assign imem_addr = fetch_pc_q;
    assign out_pc    = head.pc;
    assign out_instr = head.instr;
    assign busy      = (state_q != S_IDLE) | out_valid;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed and randomized self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    localparam logic [31:0] IMASK = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0, halt_req = 1'b0, taken_br = 1'b0, out_ready = 1'b0;
    logic [31:0] br_tgt_pc = '0;
    logic [31:0] imem_addr, imem_instr, out_pc, out_instr;
    logic        out_valid, busy;

    logic        go2 = 1'b0, halt2 = 1'b0, br2 = 1'b0, ready2 = 1'b1;
    logic [31:0] tgt2 = '0;
    logic [31:0] imem_addr2, imem_instr2, out_pc2, out_instr2;
    logic        out_valid2, busy2;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_q[$];
    logic [31:0] m_pc;
    int          m_mode;
    bit          m_valid, m_pop, m_push;

    always #5 clk = ~clk;

    assign imem_instr  = imem_addr ^ IMASK;
    assign imem_instr2 = imem_addr2 ^ IMASK;

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .go(go), .halt_req(halt_req), .taken_br(taken_br),
        .br_tgt_pc(br_tgt_pc), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .busy(busy)
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst(rst), .go(go2), .halt_req(halt2), .taken_br(br2),
        .br_tgt_pc(tgt2), .imem_addr(imem_addr2), .imem_instr(imem_instr2),
        .out_valid(out_valid2), .out_ready(ready2), .out_pc(out_pc2),
        .out_instr(out_instr2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; go = 1'b0; halt_req = 1'b0; taken_br = 1'b0; br_tgt_pc = '0;
        out_ready = 1'b0; go2 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Test 1: reset values then streaming fetch
        @(negedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_imem", imem_addr, 0);
        do_reset();
        go = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("t1_first_push_cycle_valid", out_valid, 0);
        chk("t1_busy", busy, 1);
        chk("t1_imem0", imem_addr, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t1_valid", out_valid, 1);
            chk("t1_pc", out_pc, 32'(4 * k));
            chk("t1_instr", out_instr, 32'(4 * k) ^ IMASK);
        end

        // Test 2: backpressure fills queue, fetch stalls
        do_reset();
        go = 1'b1; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("t2_full_imem", imem_addr, 32'h8);
        chk("t2_full_pc", out_pc, 0);
        @(negedge clk);
        chk("t2_stall_imem", imem_addr, 32'h8);
        chk("t2_stable_pc", out_pc, 0);
        chk("t2_stable_valid", out_valid, 1);
        out_ready = 1'b1;
        chk("t2_rel_pc0", out_pc, 0);
        @(negedge clk);
        chk("t2_rel_pc4", out_pc, 32'h4);
        @(negedge clk);
        chk("t2_rel_pc8", out_pc, 32'h8);

        // Test 3: redirect while full with a pop in the same cycle
        taken_br = 1'b1; br_tgt_pc = 32'h0000_0103;
        chk("t3_pop_valid", out_valid, 1);
        chk("t3_pop_pc", out_pc, 32'h8);
        @(negedge clk);
        taken_br = 1'b0;
        chk("t3_flushed", out_valid, 0);
        chk("t3_imem", imem_addr, 32'h100);
        chk("t3_busy", busy, 1);
        @(negedge clk);
        chk("t3_new_valid", out_valid, 1);
        chk("t3_new_pc", out_pc, 32'h100);

        // Test 4: halt with two entries, drain, resume
        go = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("t4_imem_before", imem_addr, 32'h108);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        chk("t4_imem_hold", imem_addr, 32'h108);
        chk("t4_head", out_pc, 32'h100);
        chk("t4_busy", busy, 1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_drain_pc", out_pc, 32'h104);
        chk("t4_drain_imem", imem_addr, 32'h108);
        @(negedge clk);
        chk("t4_idle_valid", out_valid, 0);
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_imem", imem_addr, 32'h108);
        go = 1'b1;
        @(negedge clk);
        chk("t4_resume_empty", out_valid, 0);
        @(negedge clk);
        chk("t4_resume_pc", out_pc, 32'h108);
        chk("t4_resume_valid", out_valid, 1);

        // Test 6: asynchronous reset mid-stream
        do_reset();
        go = 1'b1; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_pre_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_valid", out_valid, 0);
        chk("t6_async_imem", imem_addr, 0);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_pc", out_pc, 0);
        @(negedge clk);
        rst = 1'b0; go = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t6_quiet_valid", out_valid, 0);
            chk("t6_quiet_busy", busy, 0);
            chk("t6_quiet_imem", imem_addr, 0);
        end

        // Randomized run against a queue-level model
        do_reset();
        m_q.delete(); m_pc = 32'h0; m_mode = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            m_valid = (m_q.size() != 0);
            chk("rnd_valid", out_valid, m_valid);
            if (m_valid) begin
                chk("rnd_pc", out_pc, m_q[0]);
                chk("rnd_instr", out_instr, m_q[0] ^ IMASK);
            end
            chk("rnd_imem", imem_addr, m_pc);
            chk("rnd_busy", busy, (m_mode != 0 || m_valid) ? 1 : 0);
            go        = ($urandom_range(0, 3) == 0);
            halt_req  = ($urandom_range(0, 19) == 0);
            taken_br  = ($urandom_range(0, 14) == 0);
            br_tgt_pc = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            m_pop  = m_valid && out_ready;
            m_push = (m_mode == 1) && !halt_req && !taken_br && (m_q.size() < 2 || m_pop);
            if (m_pop) void'(m_q.pop_front());
            if (taken_br) begin
                m_q.delete();
                m_pc = br_tgt_pc & 32'hFFFF_FFFC;
            end else if (m_push) begin
                m_q.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
            case (m_mode)
                0: if (go && !halt_req) m_mode = 1;
                1: if (halt_req) m_mode = 2;
                default: begin
                    if (taken_br)             m_mode = 0;
                    else if (go && !halt_req) m_mode = 1;
                    else if (m_q.size() == 0) m_mode = 0;
                end
            endcase
        end

        // Test 5: PC wrap on the second instance
        do_reset();
        go2 = 1'b1;
        @(negedge clk);
        chk("t5_empty", out_valid2, 0);
        chk("t5_imem", imem_addr2, 32'hFFFF_FFF8);
        @(negedge clk);
        chk("t5_pc0", out_pc2, 32'hFFFF_FFF8);
        @(negedge clk);
        chk("t5_pc1", out_pc2, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("t5_pc2", out_pc2, 32'h0000_0000);
        chk("t5_instr2", out_instr2, IMASK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
